// File: rtl/dsc_pkg.sv
// Shared state type and width helpers for the deterministic stochastic-computing multiplier.
// Latency: none (types and constant functions only).
// Backpressure: none.
package dsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsc_state_t;

  // Result width: an exact product of n_in operands of w bits each.
  function automatic int dsc_zw(input int n_in, input int w);
    return n_in * w;
  endfunction

  // Run counter width: one bit more than the result so a full 2^ZW run fits.
  function automatic int dsc_runw(input int n_in, input int w);
    return dsc_zw(n_in, w) + 1;
  endfunction

endpackage

// File: rtl/dsc_sng_lane.sv
// One stochastic-number-generator lane: W-bit counter, terminal-count flag, unary bit x > ctr.
// Latency: the counter steps one cycle after en; tc and s are combinational from the counter.
// Backpressure: none; the counter advances only when the owning cascade enables it.
module dsc_sng_lane #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic         tc,
  output logic         s
);

  logic [W-1:0] ctr;

  // Counter restarts on operand capture and otherwise steps (wrapping) when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr <= '0;
    end else if (clr) begin
      ctr <= '0;
    end else if (en) begin
      ctr <= ctr + W'(1);
    end
  end

  assign tc = &ctr;
  assign s  = (x > ctr);

endmodule

// File: rtl/dsc_mul_param.sv
// N_IN-operand deterministic stochastic-computing multiplier with start/busy/done handshake.
// Latency: 2^ZW+1 cycles (full), x_top*2^((N_IN-1)*W)+1 (early stop), 1 when any operand is 0.
// Backpressure: start is ignored while busy; done is a one-cycle pulse, z/cycles hold until the next completion.
module dsc_mul_param
  import dsc_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              early_en,
  input  logic [N_IN*W-1:0] x,
  output logic              busy,
  output logic              done,
  output logic [N_IN*W-1:0] z,
  output logic [N_IN*W:0]   cycles
);

  localparam int ZW = dsc_zw(N_IN, W);
  localparam int RW = dsc_runw(N_IN, W);

  dsc_state_t      state;
  logic [ZW-1:0]   x_q;
  logic            early_q;
  logic [ZW-1:0]   acc;
  logic [RW-1:0]   run_cnt;

  logic [N_IN-1:0] lane_en;
  logic [N_IN-1:0] lane_tc;
  logic [N_IN-1:0] lane_s;

  logic            accept;
  logic            zero_in;
  logic            all_s;
  logic            full_last;
  logic            early_last;
  logic            last;
  logic [ZW-1:0]   acc_nxt;
  logic [RW-1:0]   run_nxt;
  logic [RW-1:0]   early_len;
  logic [W-1:0]    x_top;

  assign accept = start && ((state == IDLE) || (state == DONE));

  // Zero-operand detect on the operands being captured this cycle.
  always_comb begin
    zero_in = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (x[i*W +: W] == '0) begin
        zero_in = 1'b1;
      end
    end
  end

  // Carry cascade: lane 0 steps every RUN cycle, lane i when all lower lanes are at terminal count.
  assign lane_en[0] = (state == RUN);
  for (genvar i = 1; i < N_IN; i++) begin : g_cascade
    assign lane_en[i] = lane_en[i-1] & lane_tc[i-1];
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    dsc_sng_lane #(
      .W(W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (lane_en[i]),
      .x   (x_q[i*W +: W]),
      .tc  (lane_tc[i]),
      .s   (lane_s[i])
    );
  end

  assign all_s   = &lane_s;
  assign acc_nxt = acc + ZW'(all_s);
  assign run_nxt = run_cnt + RW'(1);

  // The run counter mirrors the concatenated lane counters, so the early stop point
  // (lower lanes saturated, top lane at x_top-1) is the cycle where it reaches x_top*2^((N_IN-1)*W)-1.
  assign x_top      = x_q[(N_IN-1)*W +: W];
  assign early_len  = RW'(x_top) << ((N_IN-1)*W);
  assign early_last = (run_nxt == early_len);
  assign full_last  = &lane_tc;
  assign last       = early_q ? early_last : full_last;

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      z       <= '0;
      cycles  <= '0;
      x_q     <= '0;
      early_q <= 1'b0;
      acc     <= '0;
      run_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            x_q     <= x;
            early_q <= early_en;
            acc     <= '0;
            run_cnt <= '0;
            if (zero_in) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              z      <= '0;
              cycles <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          run_cnt <= run_nxt;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            z      <= acc_nxt;
            cycles <= run_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_param.sv
// Scoreboard bench for dsc_mul_param across several parameterisations.
// Expected product/run length/latency come from plain arithmetic on the operands.
// A negedge monitor pops one expectation per done pulse.
module tb_dsc_mul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int NIN [6] = '{2, 4, 3, 2, 3, 4};
  localparam int WIN [6] = '{2, 3, 2, 3, 3, 4};

  logic rst, rst_d, early;
  logic start_a, start_b, start_c, start_d, start_e, start_f;
  logic busy_a, busy_b, busy_c, busy_d, busy_e, busy_f;
  logic done_a, done_b, done_c, done_d, done_e, done_f;
  logic [3:0]  x_a, z_a;  logic [4:0]  c_a;
  logic [11:0] x_b, z_b;  logic [12:0] c_b;
  logic [5:0]  x_c, z_c;  logic [6:0]  c_c;
  logic [5:0]  x_d, z_d;  logic [6:0]  c_d;
  logic [8:0]  x_e, z_e;  logic [9:0]  c_e;
  logic [15:0] x_f, z_f;  logic [16:0] c_f;

  dsc_mul_param #(.N_IN(2), .W(2)) u_a (.clk(clk), .rst(rst), .start(start_a), .early_en(early),
    .x(x_a), .busy(busy_a), .done(done_a), .z(z_a), .cycles(c_a));
  dsc_mul_param #(.N_IN(4), .W(3)) u_b (.clk(clk), .rst(rst), .start(start_b), .early_en(early),
    .x(x_b), .busy(busy_b), .done(done_b), .z(z_b), .cycles(c_b));
  dsc_mul_param #(.N_IN(3), .W(2)) u_c (.clk(clk), .rst(rst), .start(start_c), .early_en(early),
    .x(x_c), .busy(busy_c), .done(done_c), .z(z_c), .cycles(c_c));
  dsc_mul_param #(.N_IN(2), .W(3)) u_d (.clk(clk), .rst(rst_d), .start(start_d), .early_en(early),
    .x(x_d), .busy(busy_d), .done(done_d), .z(z_d), .cycles(c_d));
  dsc_mul_param #(.N_IN(3), .W(3)) u_e (.clk(clk), .rst(rst), .start(start_e), .early_en(early),
    .x(x_e), .busy(busy_e), .done(done_e), .z(z_e), .cycles(c_e));
  dsc_mul_param #(.N_IN(4), .W(4)) u_f (.clk(clk), .rst(rst), .start(start_f), .early_en(early),
    .x(x_f), .busy(busy_f), .done(done_f), .z(z_f), .cycles(c_f));

  typedef struct {
    int              id;
    longint unsigned z;
    longint unsigned c;
    longint unsigned t0;
    longint unsigned lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: product of operands; run length is 2^(N*W) in full mode,
  // x_top*2^((N-1)*W) in early mode, and 0 with 1-cycle latency if any operand is zero.
  function automatic exp_t model(input int id, input longint unsigned ops[4], input bit e);
    exp_t r;
    int n = NIN[id];
    int w = WIN[id];
    longint unsigned p = 1;
    bit zero = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = p * ops[i];
      if (ops[i] == 0) zero = 1'b1;
    end
    r.id = id;
    r.z  = p;
    r.t0 = cyc;
    if (zero) begin
      r.c   = 0;
      r.lat = 1;
    end else begin
      if (e) r.c = ops[n-1] * (64'd1 << ((n-1)*w));
      else   r.c = 64'd1 << (n*w);
      r.lat = r.c + 1;
    end
    return r;
  endfunction

  task automatic on_done(input int id, input longint unsigned zv, input longint unsigned cv, input logic bz);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_done: instance %0d pulsed done with nothing pending (cycle %0d)", id, cyc);
      return;
    end
    e = sb.pop_front();
    check("done_instance", id, e.id);
    check("z", zv, e.z);
    check("cycles", cv, e.c);
    check("latency", cyc - e.t0, e.lat);
    check("busy_at_done", bz, 0);
  endtask

  always @(negedge clk) begin
    if (done_a) on_done(0, z_a, c_a, busy_a);
    if (done_b) on_done(1, z_b, c_b, busy_b);
    if (done_c) on_done(2, z_c, c_c, busy_c);
    if (done_d) on_done(3, z_d, c_d, busy_d);
    if (done_e) on_done(4, z_e, c_e, busy_e);
    if (done_f) on_done(5, z_f, c_f, busy_f);
  end

  task automatic set_start(input int id, input logic v);
    case (id)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      3: start_d = v;
      4: start_e = v;
      default: start_f = v;
    endcase
  endtask

  // Drive operands and a one-cycle start; optionally register the expected outcome.
  task automatic issue(input int id, input longint unsigned ops[4], input bit e, input bit expect_it);
    early = e;
    case (id)
      0: for (int i = 0; i < 2; i++) x_a[i*2 +: 2] = ops[i][1:0];
      1: for (int i = 0; i < 4; i++) x_b[i*3 +: 3] = ops[i][2:0];
      2: for (int i = 0; i < 3; i++) x_c[i*2 +: 2] = ops[i][1:0];
      3: for (int i = 0; i < 2; i++) x_d[i*3 +: 3] = ops[i][2:0];
      4: for (int i = 0; i < 3; i++) x_e[i*3 +: 3] = ops[i][2:0];
      default: for (int i = 0; i < 4; i++) x_f[i*4 +: 4] = ops[i][3:0];
    endcase
    set_start(id, 1'b1);
    if (expect_it) sb.push_back(model(id, ops, e));
    @(posedge clk);
    #1;
    set_start(id, 1'b0);
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: %0d operation(s) pending after %0d cycles", sb.size(), bound);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint unsigned ops[4];
    int k;
    rst = 1'b0; rst_d = 1'b0; early = 1'b0;
    start_a = 0; start_b = 0; start_c = 0; start_d = 0; start_e = 0; start_f = 0;
    x_a = '0; x_b = '0; x_c = '0; x_d = '0; x_e = '0; x_f = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {busy_a, done_a, z_a, c_a}, 0);
    check("reset_b", {busy_b, done_b, z_b, c_b}, 0);
    check("reset_c", {busy_c, done_c, z_c, c_c}, 0);
    check("reset_d", {busy_d, done_d, z_d, c_d}, 0);
    check("reset_e", {busy_e, done_e, z_e, c_e}, 0);
    check("reset_f", {busy_f, done_f, z_f, c_f}, 0);
    rst = 1'b1; rst_d = 1'b1;
    @(posedge clk);
    #1;

    // 2x2-bit full run, then the same operands with early stop.
    issue(0, '{3, 2, 0, 0}, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_a", busy_a, 1);
    wait_drain(40);
    issue(0, '{3, 2, 0, 0}, 1'b1, 1'b1);
    wait_drain(40);

    // Zero-operand early-out: x3=5, x2=0, x1=7, x0=2.
    issue(1, '{2, 7, 0, 5}, 1'b0, 1'b1);
    check("busy_zero_b", busy_b, 0);
    wait_drain(10);

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(2, '{3, 3, 3, 0}, 1'b1, 1'b1);
    k = 0;
    while (!done_c && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", done_c, 1);
    issue(2, '{1, 1, 1, 0}, 1'b0, 1'b1);
    wait_drain(120);

    // Reset mid-run aborts silently; start and x changes while busy are ignored.
    issue(3, '{3, 5, 0, 0}, 1'b1, 1'b1);
    wait_drain(60);
    issue(3, '{7, 7, 0, 0}, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_d = 1'b0;
    #1;
    check("abort_busy", busy_d, 0);
    check("abort_done", done_d, 0);
    check("abort_z", z_d, 0);
    check("abort_cycles", c_d, 0);
    @(posedge clk);
    #1;
    rst_d = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("idle_after_abort", busy_d, 0);
    issue(3, '{6, 2, 0, 0}, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_d", busy_d, 1);
    issue(3, '{1, 1, 0, 0}, 1'b1, 1'b0);
    wait_drain(100);

    // Random regression, 3x3-bit, mixed modes and occasional zero operands.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) ops[i] = (i < 3) ? longint'($urandom_range(0, 7)) : 0;
      issue(4, ops, 1'(($urandom() >> 3) & 1), 1'b1);
      wait_drain(600);
    end

    // Random regression, 4x4-bit, early stop with a small top operand.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 3; i++) ops[i] = longint'($urandom_range(1, 15));
      ops[3] = longint'($urandom_range(1, 2));
      issue(5, ops, 1'b1, 1'b1);
      wait_drain(9000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
